// File: rtl/cordic_ln_sequencer.sv
// Sequencer for the hyperbolic-CORDIC natural-log datapath: walks LUT_Z one address per cycle.
// Moore outputs only; ROM address/enable lead EN_ITER by one cycle to hide the ROM latency.
module cordic_ln_sequencer #(
  parameter int D     = 5,
  parameter int ITERS = 24,
  parameter int SW    = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          ABORT,
  input  logic          ACK,
  output logic [D-1:0]  ADRS,
  output logic          EN_ROM1,
  output logic          LOAD_INIT,
  output logic          EN_ITER,
  output logic [SW-1:0] SHIFT,
  output logic [D-1:0]  ITER_CNT,
  output logic          BUSY,
  output logic          DONE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ITER = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  // Terminal compare on ITERS-1 so a full 2**D run never needs a D+1 bit counter.
  localparam logic [D-1:0] K_LAST = D'(ITERS - 1);

  state_t        state, state_nxt;
  logic [D-1:0]  k, k_nxt;
  logic [D-1:0]  k_plus;
  logic [SW-1:0] k_sw;

  assign k_plus = k + D'(1);
  assign k_sw   = SW'(k);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_IDLE;
      k     <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    if (ABORT) begin
      state_nxt = S_IDLE;
      k_nxt     = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) state_nxt = S_LOAD;
        end
        S_LOAD: begin
          k_nxt     = '0;
          state_nxt = S_ITER;
        end
        S_ITER: begin
          if (k == K_LAST) begin
            state_nxt = S_FIN;
          end else begin
            k_nxt = k_plus;
          end
        end
        S_FIN: begin
          if (ACK) begin
            state_nxt = S_IDLE;
            k_nxt     = '0;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          k_nxt     = '0;
        end
      endcase
    end
  end

  always_comb begin
    ADRS      = '0;
    EN_ROM1   = 1'b0;
    LOAD_INIT = 1'b0;
    EN_ITER   = 1'b0;
    SHIFT     = '0;
    ITER_CNT  = '0;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    case (state)
      S_LOAD: begin
        LOAD_INIT = 1'b1;
        EN_ROM1   = 1'b1;
        BUSY      = 1'b1;
      end
      S_ITER: begin
        EN_ITER  = 1'b1;
        BUSY     = 1'b1;
        ITER_CNT = k;
        // Shift repeats at 4 and 13 keep the hyperbolic iteration convergent.
        if (k < D'(4))       SHIFT = k_sw + SW'(1);
        else if (k < D'(14)) SHIFT = k_sw;
        else                 SHIFT = k_sw - SW'(1);
        if (k != K_LAST) begin
          ADRS    = k_plus;
          EN_ROM1 = 1'b1;
        end
      end
      S_FIN: begin
        DONE = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
